// File: rtl/dac_seg_pkg.sv
// Shared widths, types and code helpers for the segmented DAC encoder.
// The 12-bit code splits into a 7-bit binary LSB field and a 0..17 unary MSB count.
package dac_seg_pkg;

    localparam int NBIN     = 7;
    localparam int NTHERM   = 17;
    localparam int CODE_W   = 12;
    localparam int PTR_W    = 5;
    localparam int CODE_MAX = (2**NBIN - 1) + NTHERM * (2**NBIN);

    typedef logic [NBIN-1:0]   bin_t;
    typedef logic [NTHERM-1:0] therm_t;
    typedef logic [CODE_W-1:0] code_t;
    typedef logic [PTR_W-1:0]  ptr_t;
    typedef logic [PTR_W-1:0]  msb_t;

    localparam code_t CODE_MAX_C = code_t'(CODE_MAX);

    function automatic logic code_is_over(input code_t code);
        return (code > CODE_MAX_C);
    endfunction

    function automatic code_t clamp_code(input code_t code);
        return code_is_over(code) ? CODE_MAX_C : code;
    endfunction

    function automatic bin_t code_bin(input code_t code);
        return code[NBIN-1:0];
    endfunction

    // Upper five bits of a clamped code never exceed NTHERM.
    function automatic msb_t code_msb(input code_t code);
        return code[CODE_W-1:NBIN];
    endfunction

endpackage

// File: rtl/dac_therm_rotator.sv
// Places msb unary ones starting at cell ptr, wrapping modulo NTHERM,
// and returns the start pointer for the following sample.
module dac_therm_rotator
    import dac_seg_pkg::*;
(
    input  logic [PTR_W-1:0]  msb_i,
    input  logic [PTR_W-1:0]  ptr_i,
    output logic [NTHERM-1:0] therm_o,
    output logic [PTR_W-1:0]  ptr_next_o
);

    logic [PTR_W:0] sum;
    logic [PTR_W:0] sum_wrap;

    // A cell is lit when its distance from ptr (going upward, wrapping) is below msb.
    always_comb begin
        logic [PTR_W:0] idx;
        logic [PTR_W:0] off;
        therm_o = '0;
        idx     = '0;
        off     = '0;
        for (int i = 0; i < NTHERM; i++) begin
            idx = (PTR_W+1)'(i);
            if (idx >= {1'b0, ptr_i}) begin
                off = idx - {1'b0, ptr_i};
            end else begin
                off = idx + (PTR_W+1)'(NTHERM) - {1'b0, ptr_i};
            end
            therm_o[i] = (off < {1'b0, msb_i});
        end
    end

    // ptr + msb peaks at 16 + 17 = 33, so a single conditional subtract suffices.
    always_comb begin
        sum      = {1'b0, ptr_i} + {1'b0, msb_i};
        sum_wrap = sum - (PTR_W+1)'(NTHERM);
        if (sum >= (PTR_W+1)'(NTHERM)) begin
            ptr_next_o = sum_wrap[PTR_W-1:0];
        end else begin
            ptr_next_o = sum[PTR_W-1:0];
        end
    end

endmodule

// File: rtl/dac_segment_encoder.sv
// Two-stage code encoder for the segmented DAC: clamp/split, then binary plus
// rotated thermometer controls with complement rails for driver_cell.
module dac_segment_encoder
    import dac_seg_pkg::*;
(
    input  logic              clk,
    input  logic              rstb,
    input  logic              pdb,
    input  logic [CODE_W-1:0] code_in,
    input  logic              code_valid,
    input  logic              dem_en,
    output logic [NBIN-1:0]   datain,
    output logic [NBIN-1:0]   datainb,
    output logic [NTHERM-1:0] datatherm,
    output logic [NTHERM-1:0] datathermb,
    output logic              out_valid,
    output logic              sat_flag,
    output logic [PTR_W-1:0]  cell_ptr
);

    logic   s1_valid_q, s1_valid_d;
    bin_t   s1_bin_q,   s1_bin_d;
    msb_t   s1_msb_q,   s1_msb_d;
    logic   s1_sat_q,   s1_sat_d;
    logic   s1_dem_q,   s1_dem_d;

    bin_t   bin_q,    bin_d;
    bin_t   binb_q,   binb_d;
    therm_t therm_q,  therm_d;
    therm_t thermb_q, thermb_d;
    logic   valid_q,  valid_d;
    logic   sat_q,    sat_d;
    ptr_t   ptr_q,    ptr_d;

    ptr_t   rot_ptr;
    therm_t rot_therm;
    ptr_t   rot_ptr_next;
    code_t  code_clamped;

    // With DEM off every sample fills from cell 0.
    assign rot_ptr      = s1_dem_q ? ptr_q : '0;
    assign code_clamped = clamp_code(code_in);

    dac_therm_rotator u_rotator (
        .msb_i      (s1_msb_q),
        .ptr_i      (rot_ptr),
        .therm_o    (rot_therm),
        .ptr_next_o (rot_ptr_next)
    );

    always_comb begin
        s1_valid_d = 1'b0;
        s1_bin_d   = s1_bin_q;
        s1_msb_d   = s1_msb_q;
        s1_sat_d   = s1_sat_q;
        s1_dem_d   = s1_dem_q;
        if (pdb && code_valid) begin
            s1_valid_d = 1'b1;
            s1_bin_d   = code_bin(code_clamped);
            s1_msb_d   = code_msb(code_clamped);
            s1_sat_d   = code_is_over(code_in);
            s1_dem_d   = dem_en;
        end
    end

    // Power-down parks both rails low so no current switch is steered.
    always_comb begin
        bin_d    = bin_q;
        binb_d   = binb_q;
        therm_d  = therm_q;
        thermb_d = thermb_q;
        valid_d  = 1'b0;
        sat_d    = sat_q;
        ptr_d    = ptr_q;
        if (!pdb) begin
            bin_d    = '0;
            binb_d   = '0;
            therm_d  = '0;
            thermb_d = '0;
            sat_d    = 1'b0;
            ptr_d    = '0;
        end else if (s1_valid_q) begin
            bin_d    = s1_bin_q;
            binb_d   = ~s1_bin_q;
            therm_d  = rot_therm;
            thermb_d = ~rot_therm;
            valid_d  = 1'b1;
            sat_d    = s1_sat_q;
            ptr_d    = s1_dem_q ? rot_ptr_next : '0;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            s1_valid_q <= 1'b0;
            s1_bin_q   <= '0;
            s1_msb_q   <= '0;
            s1_sat_q   <= 1'b0;
            s1_dem_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_bin_q   <= s1_bin_d;
            s1_msb_q   <= s1_msb_d;
            s1_sat_q   <= s1_sat_d;
            s1_dem_q   <= s1_dem_d;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            bin_q    <= '0;
            binb_q   <= '0;
            therm_q  <= '0;
            thermb_q <= '0;
            valid_q  <= 1'b0;
            sat_q    <= 1'b0;
            ptr_q    <= '0;
        end else begin
            bin_q    <= bin_d;
            binb_q   <= binb_d;
            therm_q  <= therm_d;
            thermb_q <= thermb_d;
            valid_q  <= valid_d;
            sat_q    <= sat_d;
            ptr_q    <= ptr_d;
        end
    end

    assign datain     = bin_q;
    assign datainb    = binb_q;
    assign datatherm  = therm_q;
    assign datathermb = thermb_q;
    assign out_valid  = valid_q;
    assign sat_flag   = sat_q;
    assign cell_ptr   = ptr_q;

endmodule

// File: tb/tb_dac_segment_encoder.sv
// Directed plus randomized check of dac_segment_encoder against an arithmetic
// model of clamp, split and modulo-17 cell rotation.
module tb_dac_segment_encoder;

    logic        clk = 1'b0;
    logic        rstb;
    logic        pdb;
    logic [11:0] code_in;
    logic        code_valid;
    logic        dem_en;
    logic [6:0]  datain;
    logic [6:0]  datainb;
    logic [16:0] datatherm;
    logic [16:0] datathermb;
    logic        out_valid;
    logic        sat_flag;
    logic [4:0]  cell_ptr;

    int n_checks = 0;
    int n_fails  = 0;

    // model state
    int m_s1v, m_s1code, m_s1sat, m_s1dem;
    int m_bin, m_binb, m_therm, m_thermb, m_ov, m_sat, m_ptr;

    dac_segment_encoder dut (
        .clk        (clk),
        .rstb       (rstb),
        .pdb        (pdb),
        .code_in    (code_in),
        .code_valid (code_valid),
        .dem_en     (dem_en),
        .datain     (datain),
        .datainb    (datainb),
        .datatherm  (datatherm),
        .datathermb (datathermb),
        .out_valid  (out_valid),
        .sat_flag   (sat_flag),
        .cell_ptr   (cell_ptr)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1v = 0; m_s1code = 0; m_s1sat = 0; m_s1dem = 0;
        m_bin = 0; m_binb = 0; m_therm = 0; m_thermb = 0;
        m_ov = 0; m_sat = 0; m_ptr = 0;
    endtask

    // Applies one clock edge to the model using the currently driven inputs.
    task automatic model_edge();
        int c, msb, start;
        if (!pdb) begin
            m_bin = 0; m_binb = 0; m_therm = 0; m_thermb = 0;
            m_ov = 0; m_sat = 0; m_ptr = 0; m_s1v = 0;
            return;
        end
        if (m_s1v != 0) begin
            msb   = m_s1code / 128;
            start = (m_s1dem != 0) ? m_ptr : 0;
            m_bin  = m_s1code % 128;
            m_binb = 127 - m_bin;
            m_therm = 0;
            for (int k = 0; k < msb; k++) m_therm = m_therm | (1 << ((start + k) % 17));
            m_thermb = 'h1FFFF ^ m_therm;
            m_sat = m_s1sat;
            m_ptr = (m_s1dem != 0) ? (start + msb) % 17 : 0;
            m_ov  = 1;
        end else begin
            m_ov = 0;
        end
        m_s1v = code_valid ? 1 : 0;
        if (code_valid) begin
            c = int'(code_in);
            m_s1sat  = (c > 2303) ? 1 : 0;
            m_s1code = (c > 2303) ? 2303 : c;
            m_s1dem  = dem_en ? 1 : 0;
        end
    endtask

    task automatic check_all();
        check_val("datain",     32'(datain),     32'(m_bin));
        check_val("datainb",    32'(datainb),    32'(m_binb));
        check_val("datatherm",  32'(datatherm),  32'(m_therm));
        check_val("datathermb", 32'(datathermb), 32'(m_thermb));
        check_val("out_valid",  32'(out_valid),  32'(m_ov));
        check_val("sat_flag",   32'(sat_flag),   32'(m_sat));
        check_val("cell_ptr",   32'(cell_ptr),   32'(m_ptr));
    endtask

    task automatic cyc(input logic cv, input int code, input logic dem, input logic pd);
        code_valid = cv;
        code_in    = 12'(code);
        dem_en     = dem;
        pdb        = pd;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        int code, r;
        logic dem, pd;
        rstb = 1'b0; pdb = 1'b1; code_in = '0; code_valid = 1'b0; dem_en = 1'b0;
        model_reset();
        #2;
        check_all();
        @(posedge clk); #1;
        check_all();
        rstb = 1'b1;

        // code 0, fixed fill
        cyc(1, 0, 0, 1);
        cyc(0, 0, 0, 1);
        check_val("z_binb",   32'(datainb),    32'h7F);
        check_val("z_thermb", 32'(datathermb), 32'h1FFFF);
        check_val("z_ov",     32'(out_valid),  32'h1);
        cyc(0, 0, 0, 1);
        check_val("z_ov_once", 32'(out_valid), 32'h0);

        // mid-scale, full scale, saturation, recovery
        cyc(1, 300, 0, 1);
        cyc(1, 2303, 0, 1);
        check_val("c300_bin",   32'(datain),    32'h2C);
        check_val("c300_therm", 32'(datatherm), 32'h00003);
        cyc(1, 4000, 0, 1);
        check_val("fs_therm", 32'(datatherm), 32'h1FFFF);
        check_val("fs_sat",   32'(sat_flag),  32'h0);
        cyc(1, 5, 0, 1);
        check_val("sat_set",  32'(sat_flag),  32'h1);
        check_val("sat_bin",  32'(datain),    32'h7F);
        cyc(0, 0, 0, 1);
        check_val("sat_clr",  32'(sat_flag),  32'h0);

        // DEM rotation with back-to-back samples, then hold
        cyc(1, 1280, 1, 1);
        cyc(1, 1280, 1, 1);
        check_val("dem_therm_a", 32'(datatherm), 32'h003FF);
        check_val("dem_ptr_a",   32'(cell_ptr),  32'd10);
        cyc(0, 0, 1, 1);
        check_val("dem_therm_b", 32'(datatherm), 32'h1FC07);
        check_val("dem_ptr_b",   32'(cell_ptr),  32'd3);
        for (int i = 0; i < 3; i++) cyc(0, 77, 1, 1);

        // power-down with samples in flight
        cyc(1, 100, 1, 1);
        cyc(1, 200, 1, 0);
        check_val("pd_therm", 32'(datatherm), 32'h0);
        check_val("pd_ptr",   32'(cell_ptr),  32'h0);
        cyc(0, 0, 1, 1);
        cyc(0, 0, 1, 1);
        cyc(1, 128, 0, 1);
        cyc(0, 0, 0, 1);
        check_val("pu_therm", 32'(datatherm), 32'h00001);

        // asynchronous reset between edges
        cyc(1, 500, 1, 1);
        cyc(1, 600, 1, 1);
        #3;
        rstb = 1'b0;
        #1;
        model_reset();
        check_all();
        #2;
        rstb = 1'b1;
        cyc(1, 1, 0, 1);
        cyc(0, 0, 0, 1);
        check_val("rst_bin",  32'(datain),  32'h01);
        check_val("rst_binb", 32'(datainb), 32'h7E);

        // randomized traffic with boundary-biased codes
        dem = 1'b1;
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 2)       code = int'($urandom_range(2296, 2310));
            else if (r < 3)  code = int'($urandom_range(0, 3));
            else if (r < 4)  code = int'($urandom_range(0, 17)) * 128 + int'($urandom_range(0, 1)) * 127;
            else             code = int'($urandom_range(0, 4095));
            if ($urandom_range(0, 19) == 0) dem = ~dem;
            pd = ($urandom_range(0, 39) != 0);
            cyc(logic'($urandom_range(0, 9) < 7), code, dem, pd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
